// File: rtl/flow_table_lookup.sv
`default_nettype none
// ============================================================================
// Module   : flow_table_lookup
// Purpose  : Responder side of the forwarder's flow-lookup handshake. Holds a
//            small host-programmable masked flow table and answers each lookup
//            request with an ack exactly two cycles later. Each entry has a
//            saturating 32-bit hit counter that the host can read.
// Ports    :
//   sys_clk / sys_rst_n      clock, asynchronous active-low reset
//   of_lookup_req/_data      one-cycle lookup strobe with KEY_W-bit key
//   of_lookup_ack/_err       one-cycle response strobe, miss flag
//   of_lookup_fwd_port       NPORT-bit forwarding bitmap (0 on miss)
//   tbl_wr_*                 host table write (valid/key/mask/port)
//   stat_rd_addr/_data       hit-counter read, 1-cycle registered latency
// Revision : 1.0  initial release
// ============================================================================
module flow_table_lookup #(
    parameter int NPORT = 4,
    parameter int AW    = 3,
    parameter int KEY_W = 116
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    input  logic             of_lookup_req,
    input  logic [KEY_W-1:0] of_lookup_data,
    output logic             of_lookup_ack,
    output logic             of_lookup_err,
    output logic [NPORT-1:0] of_lookup_fwd_port,
    input  logic             tbl_wr_en,
    input  logic [AW-1:0]    tbl_wr_addr,
    input  logic             tbl_wr_valid,
    input  logic [KEY_W-1:0] tbl_wr_key,
    input  logic [KEY_W-1:0] tbl_wr_mask,
    input  logic [NPORT-1:0] tbl_wr_port,
    input  logic [AW-1:0]    stat_rd_addr,
    output logic [31:0]      stat_rd_data
);

    localparam int          NENTRY    = 2**AW;
    localparam logic [31:0] c_CNT_MAX = 32'hFFFF_FFFF;

    // Stage-1 pipeline registers
    logic             r_v1;
    logic [KEY_W-1:0] r_key_q;

    // Per-entry compare results and read-out views
    logic [NENTRY-1:0] w_match;
    logic [NENTRY-1:0] w_win;
    logic [NPORT-1:0]  w_port [NENTRY];
    logic [31:0]       w_cnt  [NENTRY];

    // Priority-resolved result
    logic              w_hit;
    logic [AW-1:0]     w_idx;

    // ------------------------------------------------------------------------
    // Stage 1: capture the key; v1 marks a lookup in flight.
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_v1    <= 1'b0;
            r_key_q <= '0;
        end else begin
            r_v1 <= of_lookup_req;
            if (of_lookup_req) begin
                r_key_q <= of_lookup_data;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Table entries. The compare reads the registered contents, so a write on
    // the same edge as a stage-2 compare is seen only by later compares.
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NENTRY; gi++) begin : g_entry
            logic             r_valid;
            logic [KEY_W-1:0] r_key;
            logic [KEY_W-1:0] r_mask;
            logic [NPORT-1:0] r_port;
            logic [31:0]      r_hit_cnt;
            logic             w_sel;

            assign w_sel = tbl_wr_en && (tbl_wr_addr == AW'(gi));

            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_valid <= 1'b0;
                    r_key   <= '0;
                    r_mask  <= '0;
                    r_port  <= '0;
                end else if (w_sel) begin
                    r_valid <= tbl_wr_valid;
                    r_key   <= tbl_wr_key;
                    r_mask  <= tbl_wr_mask;
                    r_port  <= tbl_wr_port;
                end
            end

            // A write clears the counter and takes precedence over a
            // simultaneous hit on the same entry.
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    r_hit_cnt <= '0;
                end else if (w_sel) begin
                    r_hit_cnt <= '0;
                end else if (w_win[gi] && (r_hit_cnt != c_CNT_MAX)) begin
                    r_hit_cnt <= r_hit_cnt + 32'd1;
                end
            end

            // Mask bit 1 = compare; an all-zero mask matches any key.
            assign w_match[gi] = r_valid && (((r_key_q ^ r_key) & r_mask) == '0);
            assign w_port[gi]  = r_port;
            assign w_cnt[gi]   = r_hit_cnt;
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Priority encoder: scanning from the top down leaves the lowest matching
    // index as the winner.
    // ------------------------------------------------------------------------
    always_comb begin
        w_hit = 1'b0;
        w_idx = '0;
        for (int i = NENTRY - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit = 1'b1;
                w_idx = AW'(i);
            end
        end
    end

    // One-hot strobe of the entry whose counter advances on this edge.
    always_comb begin
        w_win = '0;
        if (r_v1 && w_hit) begin
            w_win[w_idx] = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: registered response. fwd_port holds between acks.
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            of_lookup_ack      <= 1'b0;
            of_lookup_err      <= 1'b0;
            of_lookup_fwd_port <= '0;
        end else begin
            of_lookup_ack <= r_v1;
            if (r_v1) begin
                if (w_hit) begin
                    of_lookup_err      <= 1'b0;
                    of_lookup_fwd_port <= w_port[w_idx];
                end else begin
                    of_lookup_err      <= 1'b1;
                    of_lookup_fwd_port <= '0;
                end
            end else begin
                of_lookup_err <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Counter read-out: returns the value before any same-edge update.
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            stat_rd_data <= '0;
        end else begin
            stat_rd_data <= w_cnt[stat_rd_addr];
        end
    end

endmodule
`default_nettype wire
